// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: the nop encoding
// presented when no instruction is available and the fetch FSM states.
package inst_fetch_queue_pkg;

   // Existing nop encoding of the codebase, shown on inst while the head is empty.
   localparam logic [15:0] IFQ_NOP = 16'hF000;

   // Fetch FSM states.
   //   IFQ_IDLE : no request outstanding (queue full or just reset)
   //   IFQ_REQ  : request at fetch_pc outstanding, its data will be enqueued
   //   IFQ_DROP : request outstanding whose data must be discarded (redirected)
   typedef enum logic [1:0] {
      IFQ_IDLE = 2'd0,
      IFQ_REQ  = 2'd1,
      IFQ_DROP = 2'd2
   } ifq_state_e;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Instruction memory bus between the prefetch queue (master) and the
// instruction memory (slave).
//
// Handshake: mem_req is a level request; mem_addr is held stable for as long
// as mem_req=1. A transaction completes in exactly the cycle where
// mem_req & mem_ack are both high, and mem_rdata is only meaningful in that
// cycle. mem_ack while mem_req=0 has no effect. Only one transaction is ever
// outstanding and a raised request is never withdrawn before its ack.
interface inst_fetch_queue_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// DEPTH-entry ring buffer of {inst, pc_plus_1} entries for the prefetch queue.
// The caller never writes when full and never reads when empty; flush empties
// the ring in one cycle and wins over a same-cycle write or read.
module inst_fetch_queue_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   pc_reset,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] ring [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Pointer and occupancy bookkeeping; pointers wrap naturally mod DEPTH.
   always_ff @(posedge clk or posedge pc_reset) begin
      if (pc_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents need no reset because count gates their use.
   always_ff @(posedge clk) begin
      if (wr_en && !flush) ring[wr_ptr] <= wr_data;
   end

   assign rd_data = ring[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue between a multi-cycle instruction memory and the
// IF/ID register. Streams sequential instructions into a small ring and pops
// one per deq; a redirect flushes the queue and restarts fetch. A request
// already issued when a redirect arrives is completed and its data dropped.
// Optional feature macro: IFQ_BYPASS_EN (empty queue + ack + deq forwards
// mem_rdata straight to inst in the same cycle instead of enqueueing it).
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                   clk,
   input  logic                   pc_reset,
   input  logic                   redirect,
   input  logic [ADDR_W-1:0]      redirect_addr,
   inst_fetch_queue_if.master     mem,
   input  logic                   deq,
   output logic                   inst_valid,
   output logic [DATA_W-1:0]      inst,
   output logic [ADDR_W-1:0]      inst_pc_plus_1,
   output logic [$clog2(DEPTH):0] count,
   output ifq_state_e             state_dbg
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int ENT_W = DATA_W + ADDR_W;

   ifq_state_e        state;
   ifq_state_e        state_n;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] drop_addr;
   logic [ADDR_W-1:0] pc_inc;
   logic [CNT_W-1:0]  fifo_count;
   logic [ENT_W-1:0]  head;
   logic              take;
   logic              pop;
   logic              bypass;
   logic              wr_en;
   logic              slot_free;
   int                cnt_after;

   assign pc_inc = fetch_pc + ADDR_W'(1);

   // Accepted data: ack of a live (not dropped) request, not cancelled by redirect.
   assign take = (state == IFQ_REQ) && mem.mem_ack && !redirect;
   // Pops only from a non-empty queue; redirect overrides deq.
   assign pop  = deq && (fifo_count != '0) && !redirect;

`ifdef IFQ_BYPASS_EN
   assign bypass = take && (fifo_count == '0) && deq;
`else
   assign bypass = 1'b0;
`endif

   assign wr_en = take && !bypass;

   // Occupancy after this edge decides whether another request may be issued.
   always_comb begin
      cnt_after = int'(fifo_count) + int'(wr_en) - int'(pop);
      slot_free = (cnt_after < DEPTH);
   end

   // FSM state register.
   always_ff @(posedge clk or posedge pc_reset) begin
      if (pc_reset) state <= IFQ_IDLE;
      else          state <= state_n;
   end

   // FSM next state: redirect first, then ack completion and slot availability.
   always_comb begin
      state_n = state;
      case (state)
         IFQ_IDLE: begin
            if (redirect || slot_free) state_n = IFQ_REQ;
         end
         IFQ_REQ: begin
            if (redirect)          state_n = mem.mem_ack ? IFQ_REQ : IFQ_DROP;
            else if (mem.mem_ack)  state_n = slot_free ? IFQ_REQ : IFQ_IDLE;
         end
         IFQ_DROP: begin
            if (mem.mem_ack) state_n = IFQ_REQ;
         end
         default: state_n = IFQ_IDLE;
      endcase
   end

   // Fetch address and the address held on the bus while a dropped request drains.
   always_ff @(posedge clk or posedge pc_reset) begin
      if (pc_reset) begin
         fetch_pc  <= '0;
         drop_addr <= '0;
      end else begin
         if (redirect)  fetch_pc <= redirect_addr;
         else if (take) fetch_pc <= pc_inc;
         if ((state == IFQ_REQ) && redirect && !mem.mem_ack) drop_addr <= fetch_pc;
      end
   end

   assign mem.mem_req  = (state != IFQ_IDLE);
   assign mem.mem_addr = (state == IFQ_DROP) ? drop_addr : fetch_pc;

   inst_fetch_queue_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk      (clk),
      .pc_reset (pc_reset),
      .wr_en    (wr_en),
      .rd_en    (pop),
      .flush    (redirect),
      .wr_data  ({mem.mem_rdata, pc_inc}),
      .rd_data  (head),
      .count    (fifo_count)
   );

   // Head presentation: registered entry, nop when empty, or the bypassed word.
   always_comb begin
      inst_valid     = (fifo_count != '0);
      inst           = inst_valid ? head[ENT_W-1:ADDR_W] : DATA_W'(IFQ_NOP);
      inst_pc_plus_1 = inst_valid ? head[ADDR_W-1:0] : '0;
      if (bypass) begin
         inst_valid     = 1'b1;
         inst           = mem.mem_rdata;
         inst_pc_plus_1 = pc_inc;
      end
   end

   assign count     = fifo_count;
   assign state_dbg = state;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus a
// randomized run against a queue-level reference model of the prefetcher.
module tb_inst_fetch_queue;
   import inst_fetch_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = 16;
   localparam int DW    = 16;
`ifdef IFQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       pc_reset;
   logic       redirect;
   logic [15:0] redirect_addr;
   logic       deq;
   logic       inst_valid;
   logic [15:0] inst;
   logic [15:0] inst_pc_plus_1;
   logic [2:0] count;
   ifq_state_e state_dbg;

   inst_fetch_queue_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

   inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk            (clk),
      .pc_reset       (pc_reset),
      .redirect       (redirect),
      .redirect_addr  (redirect_addr),
      .mem            (mem_bus.master),
      .deq            (deq),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc_plus_1 (inst_pc_plus_1),
      .count          (count),
      .state_dbg      (state_dbg)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ---------------- reference model ----------------
   // exp_q holds {inst, pc_plus_1} in the order decode must see them.
   logic [31:0] exp_q[$];
   logic [15:0] m_pc;       // address of next instruction to be enqueued
   logic [15:0] m_old;      // address of an outstanding request being discarded
   bit          m_discard;  // next completed request must be discarded

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_pc      = 16'h0000;
      m_old     = 16'h0000;
      m_discard = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic rd, input logic [15:0] ra, input logic ak,
                        input logic [15:0] rdat, input logic dq);
      redirect          = rd;
      redirect_addr     = ra;
      mem_bus.mem_ack   = ak;
      mem_bus.mem_rdata = rdat;
      deq               = dq;
      #1;
   endtask

   // Applies the queue rules for the inputs currently driven, then crosses the edge.
   task automatic advance();
      bit fire;
      bit pop_m;
      bit byp_m;
      fire = mem_bus.mem_req && mem_bus.mem_ack;
      if (redirect) begin
         exp_q.delete();
         if (mem_bus.mem_req && !mem_bus.mem_ack) begin
            if (!m_discard) m_old = m_pc;
            m_discard = 1'b1;
         end else begin
            m_discard = 1'b0;
         end
         m_pc = redirect_addr;
      end else begin
         pop_m = deq && (exp_q.size() > 0);
         byp_m = BYP && fire && !m_discard && (exp_q.size() == 0) && deq;
         if (pop_m) void'(exp_q.pop_front());
         if (fire) begin
            if (m_discard) begin
               m_discard = 1'b0;
            end else begin
               if (!byp_m) exp_q.push_back({mem_bus.mem_rdata, m_pc + 16'd1});
               m_pc = m_pc + 16'd1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      pc_reset = 1'b1;
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      pc_reset = 1'b0;
      model_reset();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_addr !== 16'h0 || inst_valid !== 1'b0 ||
          inst !== IFQ_NOP || inst_pc_plus_1 !== 16'h0 || count !== 3'd0 || state_dbg !== IFQ_IDLE)
         begin
         errors++;
         $display("FAIL reset_values: req=%b addr=%h valid=%b inst=%h pc1=%h count=%0d state=%0d, required 0 0 0 %h 0 0 IDLE",
                  mem_bus.mem_req, mem_bus.mem_addr, inst_valid, inst, inst_pc_plus_1, count, state_dbg, IFQ_NOP);
      end
   endtask

   task automatic test_stream();
      logic [15:0] seq;
      bit started;
      int gaps;
      do_reset();
      seq = 16'h0; started = 1'b0; gaps = 0;
      for (int c = 0; c < 24; c++) begin
         drive(1'b0, 16'h0, 1'b1, mem_word(mem_bus.mem_addr), 1'b1);
         if (inst_valid) begin
            checks++;
            if (inst_pc_plus_1 !== seq + 16'd1 || inst !== mem_word(seq)) begin
               errors++;
               $display("FAIL stream_seq: inst=%h pc1=%h, required inst=%h pc1=%h",
                        inst, inst_pc_plus_1, mem_word(seq), seq + 16'd1);
            end
            seq = seq + 16'd1;
            started = 1'b1;
         end else if (started) begin
            gaps++;
         end
         advance();
      end
      checks++;
      if (gaps != 0 || seq < 16'd22) begin
         errors++;
         $display("FAIL stream_rate: delivered=%0d gaps=%0d, required >=22 delivered and 0 gaps", seq, gaps);
      end
   endtask

   task automatic test_fill();
      int acks;
      do_reset();
      acks = 0;
      for (int c = 0; c < 12; c++) begin
         drive(1'b0, 16'h0, 1'b1, mem_word(mem_bus.mem_addr), 1'b0);
         if (mem_bus.mem_req) acks++;
         advance();
      end
      checks++;
      if (acks != DEPTH || mem_bus.mem_req !== 1'b0 || count !== 3'd4 ||
          inst !== mem_word(16'h0) || inst_pc_plus_1 !== 16'h1) begin
         errors++;
         $display("FAIL fill_stop: acks=%0d req=%b count=%0d inst=%h pc1=%h, required 4 0 4 %h 0001",
                  acks, mem_bus.mem_req, count, inst, inst_pc_plus_1, mem_word(16'h0));
      end
      acks = 0;
      drive(1'b0, 16'h0, 1'b1, mem_word(mem_bus.mem_addr), 1'b1);
      if (mem_bus.mem_req) acks++;
      advance();
      for (int c = 0; c < 8; c++) begin
         drive(1'b0, 16'h0, 1'b1, mem_word(mem_bus.mem_addr), 1'b0);
         if (mem_bus.mem_req) acks++;
         advance();
      end
      checks++;
      if (acks != 1 || count !== 3'd4 || mem_bus.mem_req !== 1'b0 ||
          inst !== mem_word(16'h1) || inst_pc_plus_1 !== 16'h2) begin
         errors++;
         $display("FAIL fill_refill: acks=%0d count=%0d req=%b inst=%h pc1=%h, required 1 4 0 %h 0002",
                  acks, count, mem_bus.mem_req, inst, inst_pc_plus_1, mem_word(16'h1));
      end
   endtask

   task automatic test_drop();
      do_reset();
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      advance();
      drive(1'b1, 16'h0120, 1'b0, 16'h0, 1'b0);
      advance();
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (state_dbg !== IFQ_DROP || mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL drop_enter: state=%0d req=%b addr=%h, required DROP 1 0000",
                  state_dbg, mem_bus.mem_req, mem_bus.mem_addr);
      end
      advance();
      drive(1'b0, 16'h0, 1'b1, 16'hDEAD, 1'b0);
      checks++;
      if (mem_bus.mem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL drop_hold: addr=%h, required 0000", mem_bus.mem_addr);
      end
      advance();
      drive(1'b0, 16'h0, 1'b1, mem_word(16'h0120), 1'b0);
      checks++;
      if (count !== 3'd0 || inst_valid !== 1'b0 || mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h0120) begin
         errors++;
         $display("FAIL drop_discard: count=%0d valid=%b req=%b addr=%h, required 0 0 1 0120",
                  count, inst_valid, mem_bus.mem_req, mem_bus.mem_addr);
      end
      advance();
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (count !== 3'd1 || inst !== mem_word(16'h0120) || inst_pc_plus_1 !== 16'h0121) begin
         errors++;
         $display("FAIL drop_refetch: count=%0d inst=%h pc1=%h, required 1 %h 0121",
                  count, inst, inst_pc_plus_1, mem_word(16'h0120));
      end
   endtask

   task automatic test_redirect_ack();
      do_reset();
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      advance();
      for (int c = 0; c < 2; c++) begin
         drive(1'b0, 16'h0, 1'b1, mem_word(mem_bus.mem_addr), 1'b0);
         advance();
      end
      drive(1'b1, 16'h3000, 1'b1, 16'hBEEF, 1'b1);
      checks++;
      if (count !== 3'd2) begin
         errors++;
         $display("FAIL redir_ack_pre: count=%0d, required 2", count);
      end
      advance();
      drive(1'b0, 16'h0, 1'b1, mem_word(16'h3000), 1'b0);
      checks++;
      if (count !== 3'd0 || inst_valid !== 1'b0 || mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h3000) begin
         errors++;
         $display("FAIL redir_ack_flush: count=%0d valid=%b req=%b addr=%h, required 0 0 1 3000",
                  count, inst_valid, mem_bus.mem_req, mem_bus.mem_addr);
      end
      advance();
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (count !== 3'd1 || inst !== mem_word(16'h3000) || inst_pc_plus_1 !== 16'h3001) begin
         errors++;
         $display("FAIL redir_ack_next: count=%0d inst=%h pc1=%h, required 1 %h 3001",
                  count, inst, inst_pc_plus_1, mem_word(16'h3000));
      end
   endtask

   task automatic test_wrap();
      do_reset();
      drive(1'b1, 16'hFFFF, 1'b0, 16'h0, 1'b0);
      advance();
      drive(1'b0, 16'h0, 1'b1, mem_word(16'hFFFF), 1'b0);
      checks++;
      if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'hFFFF) begin
         errors++;
         $display("FAIL wrap_addr: req=%b addr=%h, required 1 FFFF", mem_bus.mem_req, mem_bus.mem_addr);
      end
      advance();
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (count !== 3'd1 || inst !== mem_word(16'hFFFF) || inst_pc_plus_1 !== 16'h0000 ||
          mem_bus.mem_addr !== 16'h0000 || mem_bus.mem_req !== 1'b1) begin
         errors++;
         $display("FAIL wrap_pc1: count=%0d inst=%h pc1=%h addr=%h req=%b, required 1 %h 0000 0000 1",
                  count, inst, inst_pc_plus_1, mem_bus.mem_addr, mem_bus.mem_req, mem_word(16'hFFFF));
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      advance();
      drive(1'b1, 16'h0555, 1'b0, 16'h0, 1'b0);
      advance();
      drive(1'b0, 16'h0, 1'b1, mem_word(16'h0), 1'b0);
      advance();
      for (int c = 0; c < 2; c++) begin
         drive(1'b0, 16'h0, 1'b1, mem_word(mem_bus.mem_addr), 1'b0);
         advance();
      end
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      pc_reset = 1'b1;
      #1;
      checks++;
      if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_addr !== 16'h0 || inst_valid !== 1'b0 ||
          inst !== IFQ_NOP || inst_pc_plus_1 !== 16'h0 || count !== 3'd0) begin
         errors++;
         $display("FAIL reset_mid: req=%b addr=%h valid=%b inst=%h pc1=%h count=%0d, required 0 0 0 %h 0 0",
                  mem_bus.mem_req, mem_bus.mem_addr, inst_valid, inst, inst_pc_plus_1, count, IFQ_NOP);
      end
      @(posedge clk); #1;
      pc_reset = 1'b0;
      model_reset();
   endtask

   task automatic test_bypass();
      do_reset();
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      advance();
      drive(1'b0, 16'h0, 1'b1, 16'h7E57, 1'b1);
      checks++;
`ifdef IFQ_BYPASS_EN
      if (inst_valid !== 1'b1 || inst !== 16'h7E57 || inst_pc_plus_1 !== 16'h0001) begin
         errors++;
         $display("FAIL bypass_same_cycle: valid=%b inst=%h pc1=%h, required 1 7E57 0001",
                  inst_valid, inst, inst_pc_plus_1);
      end
`else
      if (inst_valid !== 1'b0 || inst !== IFQ_NOP) begin
         errors++;
         $display("FAIL bypass_registered: valid=%b inst=%h, required 0 %h", inst_valid, inst, IFQ_NOP);
      end
`endif
      advance();
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      checks++;
`ifdef IFQ_BYPASS_EN
      if (count !== 3'd0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL bypass_no_enq: count=%0d valid=%b, required 0 0", count, inst_valid);
      end
`else
      if (count !== 3'd1 || inst !== 16'h7E57 || inst_pc_plus_1 !== 16'h0001) begin
         errors++;
         $display("FAIL bypass_enq: count=%0d inst=%h pc1=%h, required 1 7E57 0001",
                  count, inst, inst_pc_plus_1);
      end
`endif
   endtask

   task automatic test_random();
      logic        rd;
      logic [15:0] ra;
      logic        ak;
      logic        dq;
      logic [15:0] rdat;
      logic [31:0] f;
      logic        exp_v;
      logic [15:0] exp_i;
      logic [15:0] exp_p;
      logic [15:0] exp_a;
      bit          byp;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rd   = ($urandom_range(0, 19) == 0);
         ra   = 16'($urandom);
         ak   = 1'($urandom_range(0, 1));
         dq   = ($urandom_range(0, 9) < 6);
         rdat = 16'($urandom);
         drive(rd, ra, ak, rdat, dq);
         byp = BYP && mem_bus.mem_req && ak && !m_discard && !rd && (exp_q.size() == 0) && dq;
         if (byp) begin
            exp_v = 1'b1; exp_i = rdat; exp_p = m_pc + 16'd1;
         end else if (exp_q.size() > 0) begin
            f = exp_q[0];
            exp_v = 1'b1; exp_i = f[31:16]; exp_p = f[15:0];
         end else begin
            exp_v = 1'b0; exp_i = IFQ_NOP; exp_p = 16'h0;
         end
         checks++;
         if (count !== 3'(exp_q.size()) || inst_valid !== exp_v || inst !== exp_i || inst_pc_plus_1 !== exp_p) begin
            errors++;
            $display("FAIL rand_head c=%0d: count=%0d valid=%b inst=%h pc1=%h, required %0d %b %h %h",
                     c, count, inst_valid, inst, inst_pc_plus_1, exp_q.size(), exp_v, exp_i, exp_p);
         end
         if (mem_bus.mem_req) begin
            exp_a = m_discard ? m_old : m_pc;
            checks++;
            if (mem_bus.mem_addr !== exp_a || (!m_discard && exp_q.size() >= DEPTH)) begin
               errors++;
               $display("FAIL rand_req c=%0d: addr=%h occupancy=%0d, required addr=%h with a free slot",
                        c, mem_bus.mem_addr, exp_q.size(), exp_a);
            end
         end
         advance();
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      pc_reset          = 1'b1;
      redirect          = 1'b0;
      redirect_addr     = 16'h0;
      deq               = 1'b0;
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 16'h0;
      model_reset();
      test_reset();
      test_stream();
      test_fill();
      test_drop();
      test_redirect_ack();
      test_wrap();
      test_reset_mid();
      test_bypass();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
